memory_access_stage: RTL and testbench

//  MEM stage: consumes EX→MEM fields, issues load/store to data memory via valid/ready

---
 rtl/memory_access_stage.sv | 262 ++++++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues load/store requests over a valid/ready data-memory port,
// aligns and extends load data, and registers the write-back fields.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_w_data,
  input  logic [1:0]  in_mem_width,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_rd_we,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic        in_is_load_unsigned,
  output logic        stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_r_data,
  output logic [31:0] wb_alu_result,
  output logic        wb_is_load,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_rd_we,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  // Load context captured at request acceptance, used when the response returns
  logic [1:0]  ld_off_q, ld_off_d;
  logic [1:0]  ld_width_q, ld_width_d;
  logic        ld_unsigned_q, ld_unsigned_d;
  logic [31:0] ld_pc_q, ld_pc_d;
  logic [31:0] ld_alu_q, ld_alu_d;
  logic [4:0]  ld_rd_addr_q, ld_rd_addr_d;
  logic        ld_rd_we_q, ld_rd_we_d;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_r_data_q, wb_r_data_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic        wb_is_load_q, wb_is_load_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic        wb_rd_we_q, wb_rd_we_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_error_q, bus_error_d;

  logic [1:0]  off;
  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic        mis;
  logic        accepted;
  logic        retire_now;

  function automatic logic [31:0] load_extend(
    input logic [31:0] raw,
    input logic [1:0]  byte_off,
    input logic [1:0]  width,
    input logic        is_unsigned
  );
    logic [31:0] w;
    logic [31:0] res;
    w = raw >> {byte_off, 3'b000};
    case (width)
      2'b00:   res = is_unsigned ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   res = is_unsigned ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  assign off     = in_alu_result[1:0];
  assign mem_op  = in_is_load | in_is_store;
  assign is_half = (in_mem_width == 2'b01);
  assign is_word = in_mem_width[1];
  assign mis     = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));

  assign dmem_addr = {in_alu_result[31:2], 2'b00};
  assign dmem_we   = in_is_store;

  always_comb begin
    dmem_wdata = in_w_data;
    dmem_be    = 4'b1111;
    case (in_mem_width)
      2'b00: begin
        dmem_wdata = {4{in_w_data[7:0]}};
        dmem_be    = 4'b0001 << off;
      end
      2'b01: begin
        dmem_wdata = {2{in_w_data[15:0]}};
        dmem_be    = 4'b0011 << off;
      end
      default: begin
        dmem_wdata = in_w_data;
        dmem_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ld_off_d        = ld_off_q;
    ld_width_d      = ld_width_q;
    ld_unsigned_d   = ld_unsigned_q;
    ld_pc_d         = ld_pc_q;
    ld_alu_d        = ld_alu_q;
    ld_rd_addr_d    = ld_rd_addr_q;
    ld_rd_we_d      = ld_rd_we_q;
    wb_valid_d      = 1'b0;
    wb_pc_d         = wb_pc_q;
    wb_r_data_d     = wb_r_data_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_is_load_d    = wb_is_load_q;
    wb_rd_addr_d    = wb_rd_addr_q;
    wb_rd_we_d      = wb_rd_we_q;
    misaligned_d    = 1'b0;
    bus_error_d     = 1'b0;
    stall           = 1'b0;
    dmem_req_valid  = 1'b0;
    accepted        = 1'b0;
    retire_now      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_op && !mis) begin
            dmem_req_valid = 1'b1;
            accepted       = dmem_req_ready;
            // Only an accepted store retires here; loads keep stalling into WAIT_RSP
            stall          = !(dmem_req_ready && in_is_store);
          end
          retire_now = !mem_op || mis || (accepted && in_is_store);
          if (retire_now) begin
            wb_valid_d      = 1'b1;
            wb_pc_d         = in_pc;
            wb_alu_result_d = in_alu_result;
            wb_r_data_d     = '0;
            wb_is_load_d    = in_is_load;
            wb_rd_addr_d    = in_rd_addr;
            wb_rd_we_d      = in_rd_we && !mem_op;
            misaligned_d    = mis;
          end
          if (accepted && in_is_load) begin
            ld_off_d      = off;
            ld_width_d    = in_mem_width;
            ld_unsigned_d = in_is_load_unsigned;
            ld_pc_d       = in_pc;
            ld_alu_d      = in_alu_result;
            ld_rd_addr_d  = in_rd_addr;
            ld_rd_we_d    = in_rd_we;
            cnt_d         = '0;
            state_d       = WAIT_RSP;
          end
        end
      end

      WAIT_RSP: begin
        stall = 1'b1;
        if (dmem_rsp_valid) begin
          stall           = 1'b0;
          wb_valid_d      = 1'b1;
          wb_pc_d         = ld_pc_q;
          wb_alu_result_d = ld_alu_q;
          wb_r_data_d     = load_extend(dmem_rsp_data, ld_off_q, ld_width_q, ld_unsigned_q);
          wb_is_load_d    = 1'b1;
          wb_rd_addr_d    = ld_rd_addr_q;
          wb_rd_we_d      = ld_rd_we_q;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1)) begin
            stall           = 1'b0;
            bus_error_d     = 1'b1;
            wb_valid_d      = 1'b1;
            wb_pc_d         = ld_pc_q;
            wb_alu_result_d = ld_alu_q;
            wb_r_data_d     = '0;
            wb_is_load_d    = 1'b1;
            wb_rd_addr_d    = ld_rd_addr_q;
            wb_rd_we_d      = 1'b0;
            cnt_d           = '0;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ld_off_q        <= '0;
      ld_width_q      <= '0;
      ld_unsigned_q   <= 1'b0;
      ld_pc_q         <= '0;
      ld_alu_q        <= '0;
      ld_rd_addr_q    <= '0;
      ld_rd_we_q      <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_pc_q         <= '0;
      wb_r_data_q     <= '0;
      wb_alu_result_q <= '0;
      wb_is_load_q    <= 1'b0;
      wb_rd_addr_q    <= '0;
      wb_rd_we_q      <= 1'b0;
      misaligned_q    <= 1'b0;
      bus_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ld_off_q        <= ld_off_d;
      ld_width_q      <= ld_width_d;
      ld_unsigned_q   <= ld_unsigned_d;
      ld_pc_q         <= ld_pc_d;
      ld_alu_q        <= ld_alu_d;
      ld_rd_addr_q    <= ld_rd_addr_d;
      ld_rd_we_q      <= ld_rd_we_d;
      wb_valid_q      <= wb_valid_d;
      wb_pc_q         <= wb_pc_d;
      wb_r_data_q     <= wb_r_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_is_load_q    <= wb_is_load_d;
      wb_rd_addr_q    <= wb_rd_addr_d;
      wb_rd_we_q      <= wb_rd_we_d;
      misaligned_q    <= misaligned_d;
      bus_error_q     <= bus_error_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_pc         = wb_pc_q;
  assign wb_r_data     = wb_r_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_is_load    = wb_is_load_q;
  assign wb_rd_addr    = wb_rd_addr_q;
  assign wb_rd_we      = wb_rd_we_q;
  assign misaligned    = misaligned_q;
  assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage against an arithmetic model of the MEM stage.
module tb_memory_access_stage;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0, in_alu_result = '0, in_w_data = '0;
  logic [1:0]  in_mem_width = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        in_rd_we = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0, in_is_load_unsigned = 1'b0;
  logic        stall, dmem_req_valid, dmem_we;
  logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rsp_data = '0;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_is_load, wb_rd_we, misaligned, bus_error;
  logic [31:0] wb_pc, wb_r_data, wb_alu_result;
  logic [4:0]  wb_rd_addr;

  int checks = 0;
  int failures = 0;

  memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_alu_result(in_alu_result),
    .in_w_data(in_w_data), .in_mem_width(in_mem_width), .in_rd_addr(in_rd_addr),
    .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_is_load_unsigned(in_is_load_unsigned), .stall(stall), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_data(dmem_rsp_data), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_r_data(wb_r_data),
    .wb_alu_result(wb_alu_result), .wb_is_load(wb_is_load), .wb_rd_addr(wb_rd_addr),
    .wb_rd_we(wb_rd_we), .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 alu, 1 load, 2 store
    logic [31:0] pc, alu, wdata;
    logic [1:0]  width;
    logic [4:0]  rd;
    logic        we, uns;
  } op_t;

  typedef struct {
    int          stall_cycles, req_cycles, early_wb;
    bit          stable, hung, clean, wbv, rd_we, is_load, mis, berr;
    logic [31:0] addr, wdata, pc, alu, r_data;
    logic [3:0]  be;
    logic        we;
    logic [4:0]  rd;
  } obs_t;

  typedef struct {
    int          stall_cycles, req_cycles;
    bit          rd_we, mis, berr;
    logic [31:0] addr, wdata, r_data;
    logic [3:0]  be;
  } exp_t;

  // Reference: lane selection and extension done with integer arithmetic on byte values
  function automatic exp_t model(input op_t op, input int ready_lat, input int rsp_lat,
                                 input logic [31:0] rsp);
    exp_t e;
    longint unsigned off, v, d;
    bit is_mis, to;
    off = longint'(op.alu % 4);
    d   = longint'(op.wdata);
    is_mis = (op.kind != 0) && ((op.width == 1 && off % 2 == 1) || (op.width >= 2 && off != 0));
    to = (rsp_lat < 0) || (rsp_lat >= T);
    e.addr = op.alu - (op.alu % 4);
    e.mis = is_mis;
    e.berr = 1'b0;
    e.r_data = '0;
    e.stall_cycles = 0;
    e.req_cycles = 0;
    e.rd_we = (op.kind == 0) ? op.we : 1'b0;
    e.wdata = op.wdata;
    e.be = 4'hF;
    if (op.width == 0) begin
      e.wdata = 32'((d % 256) * 64'h01010101);
      e.be = 4'(longint'(1) << off);
    end else if (op.width == 1) begin
      e.wdata = 32'((d % 65536) * 64'h00010001);
      e.be = 4'(longint'(3) << off);
    end
    if (op.kind != 0 && !is_mis) begin
      e.req_cycles = ready_lat + 1;
      e.stall_cycles = ready_lat;
      if (op.kind == 1) begin
        if (to) begin
          e.stall_cycles = ready_lat + T;
          e.berr = 1'b1;
        end else begin
          e.stall_cycles = ready_lat + 1 + rsp_lat;
          e.rd_we = op.we;
          v = (longint'(rsp) / (longint'(1) << (8 * off)));
          if (op.width == 0) begin
            v = v % 256;
            e.r_data = (!op.uns && v >= 128) ? 32'(v + 64'hFFFFFF00) : 32'(v);
          end else if (op.width == 1) begin
            v = v % 65536;
            e.r_data = (!op.uns && v >= 32768) ? 32'(v + 64'hFFFF0000) : 32'(v);
          end else begin
            e.r_data = rsp;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic run_op(input op_t op, input int ready_lat, input int rsp_lat,
                        input logic [31:0] rsp, output obs_t ob);
    int reqcnt, waitcnt;
    bit accepted, acc_now, done;
    reqcnt = 0; waitcnt = 0; accepted = 0; done = 0;
    ob.stall_cycles = 0; ob.early_wb = 0; ob.stable = 1; ob.wbv = 0; ob.mis = 0; ob.berr = 0;
    ob.addr = '0; ob.wdata = '0; ob.be = '0; ob.we = 1'b0;
    in_valid = 1'b1; in_pc = op.pc; in_alu_result = op.alu; in_w_data = op.wdata;
    in_mem_width = op.width; in_rd_addr = op.rd; in_rd_we = op.we;
    in_is_load = (op.kind == 1); in_is_store = (op.kind == 2); in_is_load_unsigned = op.uns;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      dmem_req_ready = (reqcnt >= ready_lat);
      dmem_rsp_valid = accepted && (waitcnt == rsp_lat);
      dmem_rsp_data  = dmem_rsp_valid ? rsp : $urandom;
      @(negedge clk);
      acc_now = dmem_req_valid && dmem_req_ready;
      if (dmem_req_valid) begin
        if (reqcnt == 0) begin
          ob.addr = dmem_addr; ob.wdata = dmem_wdata; ob.be = dmem_be; ob.we = dmem_we;
        end else if (ob.addr !== dmem_addr || ob.wdata !== dmem_wdata ||
                     ob.be !== dmem_be || ob.we !== dmem_we) begin
          ob.stable = 0;
        end
        reqcnt++;
      end
      if (stall) ob.stall_cycles++;
      else done = 1;
      @(posedge clk); #1;
      if (done) begin
        ob.wbv = wb_valid; ob.pc = wb_pc; ob.alu = wb_alu_result; ob.r_data = wb_r_data;
        ob.is_load = wb_is_load; ob.rd = wb_rd_addr; ob.rd_we = wb_rd_we;
        ob.mis = misaligned; ob.berr = bus_error;
      end else if (wb_valid) begin
        ob.early_wb++;
      end
      if (accepted) waitcnt++;
      if (acc_now) accepted = 1;
    end
    ob.hung = !done;
    ob.req_cycles = reqcnt;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    ob.clean = !wb_valid && !misaligned && !bus_error;
  endtask

  function automatic op_t mk(input int kind, input logic [31:0] alu, input logic [1:0] width,
                             input logic uns, input logic [31:0] wdata);
    op_t o;
    o.kind = kind; o.alu = alu; o.width = width; o.uns = uns; o.wdata = wdata;
    o.pc = $urandom & 32'hFFFF_FFFC; o.rd = 5'($urandom_range(1, 31)); o.we = 1'b1;
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_alu_result = 32'h55; in_pc = 32'h40; in_rd_we = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({stall, dmem_req_valid} !== 2'b00) begin failures++; $display("FAIL reset_comb got=%b exp=00", {stall, dmem_req_valid}); end
    @(posedge clk); #1;
    checks++; if ({wb_pc, wb_alu_result, wb_r_data, wb_rd_addr, wb_rd_we, wb_is_load, misaligned, bus_error} !== '0) begin
      failures++; $display("FAIL reset_regs got pc=%h alu=%h rd=%h", wb_pc, wb_alu_result, wb_r_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    op_t o; obs_t ob;
    o = mk(0, 32'h1234, 2'b10, 1'b0, 32'h0); o.rd = 5'd5;
    run_op(o, 0, 0, 32'h0, ob);
    checks++; if (ob.stall_cycles !== 0 || ob.req_cycles !== 0) begin failures++; $display("FAIL alu_stall got=%0d/%0d exp=0/0", ob.stall_cycles, ob.req_cycles); end
    checks++; if ({ob.wbv, ob.rd_we, ob.rd} !== {1'b1, 1'b1, 5'd5}) begin failures++; $display("FAIL alu_wb got=%b%b rd=%0d exp=11 rd=5", ob.wbv, ob.rd_we, ob.rd); end
    checks++; if (ob.alu !== 32'h1234 || ob.r_data !== 32'h0 || ob.pc !== o.pc) begin failures++; $display("FAIL alu_data got=%h/%h exp=00001234/0", ob.alu, ob.r_data); end
    checks++; if (!ob.clean) begin failures++; $display("FAIL alu_pulse got=held exp=one_cycle"); end
  endtask

  task automatic test_load();
    op_t o; obs_t ob;
    o = mk(1, 32'h1003, 2'b00, 1'b0, 32'h0);
    run_op(o, 0, 3, 32'h8000_0000, ob);
    checks++; if (ob.addr !== 32'h1000) begin failures++; $display("FAIL lb_addr got=%h exp=00001000", ob.addr); end
    checks++; if (ob.stall_cycles !== 4) begin failures++; $display("FAIL lb_stall got=%0d exp=4", ob.stall_cycles); end
    checks++; if (ob.r_data !== 32'hFFFF_FF80 || ob.is_load !== 1'b1 || ob.rd !== o.rd || ob.pc !== o.pc) begin
      failures++; $display("FAIL lb_data got=%h is_load=%b exp=ffffff80 is_load=1", ob.r_data, ob.is_load);
    end
    o.uns = 1'b1;
    run_op(o, 1, 3, 32'h8000_0000, ob);
    checks++; if (ob.r_data !== 32'h0000_0080 || ob.stall_cycles !== 5) begin failures++; $display("FAIL lbu_data got=%h stall=%0d exp=00000080 stall=5", ob.r_data, ob.stall_cycles); end
    checks++; if (ob.early_wb !== 0 || !ob.clean) begin failures++; $display("FAIL lb_wb_once got=%0d exp=0", ob.early_wb); end
  endtask

  task automatic test_store();
    op_t o; obs_t ob;
    o = mk(2, 32'h2002, 2'b01, 1'b0, 32'hABCD_1234);
    run_op(o, 2, 0, 32'h0, ob);
    checks++; if (ob.wdata !== 32'h1234_1234 || ob.be !== 4'b1100 || ob.we !== 1'b1) begin
      failures++; $display("FAIL sh_lanes got=%h be=%b we=%b exp=12341234 be=1100 we=1", ob.wdata, ob.be, ob.we);
    end
    checks++; if (ob.stall_cycles !== 2 || ob.req_cycles !== 3 || !ob.stable) begin
      failures++; $display("FAIL sh_hold got stall=%0d req=%0d stable=%b exp 2/3/1", ob.stall_cycles, ob.req_cycles, ob.stable);
    end
    checks++; if ({ob.wbv, ob.rd_we, ob.mis} !== 3'b100) begin failures++; $display("FAIL sh_wb got=%b exp=100", {ob.wbv, ob.rd_we, ob.mis}); end
  endtask

  task automatic test_misaligned();
    op_t o; obs_t ob;
    o = mk(1, 32'h1002, 2'b10, 1'b0, 32'h0);
    run_op(o, 0, 0, 32'h0, ob);
    checks++; if (ob.req_cycles !== 0 || ob.stall_cycles !== 0) begin failures++; $display("FAIL lw_mis_req got=%0d/%0d exp=0/0", ob.req_cycles, ob.stall_cycles); end
    checks++; if ({ob.wbv, ob.rd_we, ob.mis, ob.berr} !== 4'b1010) begin failures++; $display("FAIL lw_mis_wb got=%b exp=1010", {ob.wbv, ob.rd_we, ob.mis, ob.berr}); end
    checks++; if (!ob.clean) begin failures++; $display("FAIL mis_pulse got=held exp=one_cycle"); end
  endtask

  task automatic test_timeout();
    op_t o; obs_t ob;
    o = mk(1, 32'h3000, 2'b10, 1'b0, 32'h0);
    run_op(o, 0, -1, 32'h0, ob);
    checks++; if (ob.stall_cycles !== T || ob.hung) begin failures++; $display("FAIL timeout_stall got=%0d exp=%0d", ob.stall_cycles, T); end
    checks++; if ({ob.wbv, ob.rd_we, ob.berr, ob.mis} !== 4'b1010) begin failures++; $display("FAIL timeout_wb got=%b exp=1010", {ob.wbv, ob.rd_we, ob.berr, ob.mis}); end
    checks++; if (!ob.clean) begin failures++; $display("FAIL berr_pulse got=held exp=one_cycle"); end
    o = mk(0, 32'h77, 2'b10, 1'b0, 32'h0);
    run_op(o, 0, 0, 32'h0, ob);
    checks++; if (ob.stall_cycles !== 0 || ob.alu !== 32'h77) begin failures++; $display("FAIL timeout_idle got=%0d exp=0", ob.stall_cycles); end
  endtask

  task automatic test_reset_mid_wait();
    op_t o; obs_t ob; int wbs;
    wbs = 0;
    in_valid = 1'b1; in_alu_result = 32'h4000; in_mem_width = 2'b10; in_is_load = 1'b1;
    in_is_store = 1'b0; in_rd_we = 1'b1; dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    checks++; if ({stall, dmem_req_valid} !== 2'b10) begin failures++; $display("FAIL rstwait_pending got=%b exp=10", {stall, dmem_req_valid}); end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dmem_rsp_valid = (i == 1); dmem_rsp_data = 32'hDEAD_BEEF;
      @(negedge clk);
      if (stall) wbs++;
      @(posedge clk); #1;
      if (wb_valid) wbs++;
    end
    dmem_rsp_valid = 1'b0;
    checks++; if (wbs !== 0) begin failures++; $display("FAIL rstwait_dropped got=%0d exp=0", wbs); end
    o = mk(0, 32'h9ABC, 2'b10, 1'b0, 32'h0);
    run_op(o, 0, 0, 32'h0, ob);
    checks++; if (ob.stall_cycles !== 0 || ob.wbv !== 1'b1 || ob.alu !== 32'h9ABC) begin
      failures++; $display("FAIL rstwait_next got stall=%0d alu=%h exp 0/00009abc", ob.stall_cycles, ob.alu);
    end
  endtask

  task automatic test_back_to_back();
    op_t o; obs_t ob; exp_t e;
    int rl, sl;
    logic [31:0] rsp;
    for (int n = 0; n < 60; n++) begin
      o = mk($urandom_range(0, 2), $urandom, 2'($urandom_range(0, 3)), 1'($urandom), $urandom);
      if ($urandom_range(0, 3) != 0) o.alu[1:0] = (o.width == 0) ? o.alu[1:0] : (o.width == 1) ? {o.alu[1], 1'b0} : 2'b00;
      rl = $urandom_range(0, 3);
      sl = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T + 1));
      rsp = $urandom;
      e = model(o, rl, sl, rsp);
      run_op(o, rl, sl, rsp, ob);
      checks++; if (ob.stall_cycles !== e.stall_cycles || ob.req_cycles !== e.req_cycles || ob.hung) begin
        failures++; $display("FAIL b2b_timing[%0d] got stall=%0d req=%0d exp stall=%0d req=%0d", n, ob.stall_cycles, ob.req_cycles, e.stall_cycles, e.req_cycles);
      end
      checks++; if ({ob.wbv, ob.rd_we, ob.mis, ob.berr} !== {1'b1, e.rd_we, e.mis, e.berr} || ob.early_wb !== 0 || !ob.clean) begin
        failures++; $display("FAIL b2b_wb[%0d] got=%b exp=%b", n, {ob.wbv, ob.rd_we, ob.mis, ob.berr}, {1'b1, e.rd_we, e.mis, e.berr});
      end
      checks++; if (ob.pc !== o.pc || ob.alu !== o.alu || ob.rd !== o.rd || (o.kind != 2 && !e.mis && ob.r_data !== e.r_data)) begin
        failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", n, ob.r_data, e.r_data);
      end
      if (e.req_cycles > 0) begin
        checks++; if (ob.addr !== e.addr || !ob.stable || ob.we !== (o.kind == 2) ||
                      (o.kind == 2 && (ob.wdata !== e.wdata || ob.be !== e.be))) begin
          failures++; $display("FAIL b2b_req[%0d] got addr=%h wd=%h be=%b exp addr=%h wd=%h be=%b", n, ob.addr, ob.wdata, ob.be, e.addr, e.wdata, e.be);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
